fetch_ctrl: RTL and testbench

Fetch-stage sequencer between the PC/fetch stage, the decode pipeline register and a variable-latency instruction memory with a request/grant/response handshake. It issues one instruction fetch at a time and generates `en_fetch`, `en_decode` and `CLR_decode` for the fetch/decode pipeline. It resolves execute-stage redirects and load-use stalls against an outstanding fetch: it discards wrong-path responses, inserts bubbles and buffers stalled instructions. It also keeps a saturating fetch-stall counter for performance monitoring.

---
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Instruction-memory request/grant/response bus for fetch_ctrl.
// Revision : 1.0
// ============================================================================
interface fetch_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [WIDTH-1:0]      imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding fetch sequencer driving fetch/decode enables,
//            with redirect/stall resolution and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter int                    WIDTH      = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP        = 32'h00000013
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [WIDTH-1:0]      PCF,
    input  wire logic [1:0]            PCSrcE,
    input  wire logic                  StallReq,
    fetch_ctrl_if.master               imem,
    output logic                       en_fetch,
    output logic                       en_decode,
    output logic                       CLR_decode,
    output logic [DATA_WIDTH-1:0]      InstrDi,
    output logic [15:0]                stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [15:0]           r_stall_cnt;

    logic                  w_redirect;
    logic                  w_req;
    logic                  w_deliver;
    logic                  w_flush;
    logic                  w_buf_load;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_redirect = |PCSrcE;

    // Next state and cycle classification (deliver / flush / neither)
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_deliver  = 1'b0;
        w_flush    = 1'b0;
        w_buf_load = 1'b0;
        w_data     = NOP;
        case (r_state)
            S_IDLE: begin
                w_next = S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_next  = imem.imem_gnt ? S_DROP : S_REQ;
                end else if (imem.imem_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_next  = imem.imem_rvalid ? S_REQ : S_DROP;
                end else if (imem.imem_rvalid) begin
                    if (StallReq) begin
                        w_buf_load = 1'b1;
                        w_next     = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        w_data    = imem.imem_rdata;
                        w_next    = S_REQ;
                    end
                end
            end
            S_DROP: begin
                // Wrong-path response still owed by memory; swallow it first
                if (w_redirect) begin
                    w_flush = 1'b1;
                end else if (imem.imem_rvalid) begin
                    w_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_next  = S_REQ;
                end else if (!StallReq) begin
                    w_deliver = 1'b1;
                    w_data    = r_buf;
                    w_next    = S_REQ;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pipeline controls; reset forces a decode bubble and no request
    always_comb begin
        imem.imem_req = 1'b0;
        en_fetch      = 1'b0;
        en_decode     = 1'b1;
        CLR_decode    = 1'b1;
        InstrDi       = NOP;
        if (rst) begin
            imem.imem_req = w_req;
            if (w_flush) begin
                en_fetch   = 1'b1;
                en_decode  = 1'b1;
                CLR_decode = 1'b1;
            end else if (w_deliver) begin
                en_fetch   = 1'b1;
                en_decode  = 1'b1;
                CLR_decode = 1'b0;
                InstrDi    = w_data;
            end else begin
                en_decode  = !StallReq;
                CLR_decode = !StallReq;
            end
        end
    end

    assign imem.imem_addr = PCF;
    assign stall_cycles   = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_buf       <= NOP;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_buf_load) begin
                r_buf <= imem.imem_rdata;
            end
            if (!en_fetch && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl with a per-cycle model.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PCF = '0;
    logic [1:0]  PCSrcE = '0;
    logic        StallReq = 1'b0;
    logic        en_fetch, en_decode, CLR_decode;
    logic [31:0] InstrDi;
    logic [15:0] stall_cycles;

    fetch_ctrl_if #(.WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_ctrl #(.WIDTH(32), .DATA_WIDTH(32), .NOP(c_NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .PCSrcE       (PCSrcE),
        .StallReq     (StallReq),
        .imem         (bus.master),
        .en_fetch     (en_fetch),
        .en_decode    (en_decode),
        .CLR_decode   (CLR_decode),
        .InstrDi      (InstrDi),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether a fetch is in flight, whether it is
    // wrong-path, and whether a stalled instruction is parked.
    bit          m_first, m_inflight, m_wrong, m_bvalid;
    logic [31:0] m_buf;
    int          m_cnt;
    int          k;            // 0 none, 1 deliver, 2 flush, 3 reset
    logic [31:0] e_data;
    bit          e_req, e_ef, e_ed, e_clr;

    always @(negedge clk) begin
        e_req  = 1'b0;
        e_data = c_NOP;
        k      = 0;
        if (!rst) begin
            k = 3;
            m_first = 1; m_inflight = 0; m_wrong = 0; m_bvalid = 0;
        end else if (m_first) begin
            m_first = 0;
        end else if (m_bvalid) begin
            if (PCSrcE != 0)    begin k = 2; m_bvalid = 0; end
            else if (!StallReq) begin k = 1; e_data = m_buf; m_bvalid = 0; end
        end else if (m_inflight) begin
            if (m_wrong) begin
                if (PCSrcE != 0)             k = 2;
                else if (bus.imem_rvalid)    m_inflight = 0;
            end else if (PCSrcE != 0) begin
                k = 2;
                if (bus.imem_rvalid) m_inflight = 0;
                else                 m_wrong = 1;
            end else if (bus.imem_rvalid) begin
                m_inflight = 0;
                if (StallReq) begin m_bvalid = 1; m_buf = bus.imem_rdata; end
                else          begin k = 1; e_data = bus.imem_rdata; end
            end
        end else begin
            e_req = 1'b1;
            if (PCSrcE != 0) k = 2;
            if (bus.imem_gnt) begin
                m_inflight = 1;
                m_wrong    = (PCSrcE != 0);
            end
        end

        case (k)
            1:       begin e_ef = 1; e_ed = 1; e_clr = 0; end
            2:       begin e_ef = 1; e_ed = 1; e_clr = 1; end
            3:       begin e_ef = 0; e_ed = 1; e_clr = 1; end
            default: begin e_ef = 0; e_ed = !StallReq; e_clr = !StallReq; end
        endcase

        chk("model imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
        if (e_req) chk("model imem_addr", bus.imem_addr, PCF);
        chk("model en_fetch", {31'd0, en_fetch}, {31'd0, e_ef});
        chk("model en_decode", {31'd0, en_decode}, {31'd0, e_ed});
        chk("model CLR_decode", {31'd0, CLR_decode}, {31'd0, e_clr});
        chk("model InstrDi", InstrDi, e_data);
        if (rst) chk("model stall_cycles", {16'd0, stall_cycles}, m_cnt[31:0]);

        if (!rst)                    m_cnt = 0;
        else if (!e_ef && m_cnt < 65535) m_cnt++;
    end

    logic        s_req, s_ef, s_ed, s_clr;
    logic [31:0] s_addr, s_instr;
    logic [15:0] s_cnt;

    task automatic cyc(input bit r, input logic [31:0] pc, input logic [1:0] src,
                       input bit st, input bit g, input bit rv, input logic [31:0] rd);
        rst             = r;
        PCF             = pc;
        PCSrcE          = src;
        StallReq        = st;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #2;
        s_req = bus.imem_req; s_addr = bus.imem_addr; s_ef = en_fetch;
        s_ed = en_decode; s_clr = CLR_decode; s_instr = InstrDi; s_cnt = stall_cycles;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req"}, {31'd0, s_req}, 32'd0);
        chk({nm, " en_fetch"}, {31'd0, s_ef}, 32'd0);
        chk({nm, " en_decode"}, {31'd0, s_ed}, 32'd1);
        chk({nm, " CLR"}, {31'd0, s_clr}, 32'd1);
        chk({nm, " InstrDi"}, s_instr, c_NOP);
    endtask

    initial begin
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        chk_reset_outputs("reset");
        chk("reset stall_cycles", {16'd0, s_cnt}, 32'd0);

        // Zero-wait stream
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("idle req", {31'd0, s_req}, 32'd0);
        chk("idle stall_cycles", {16'd0, s_cnt}, 32'd0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("req1 req", {31'd0, s_req}, 32'd1);
        chk("req1 addr", s_addr, 32'd0);
        chk("req1 en_fetch", {31'd0, s_ef}, 32'd0);
        cyc(1, 0, 0, 0, 0, 1, 32'h00500093);
        chk("dlv1 InstrDi", s_instr, 32'h00500093);
        chk("dlv1 en_fetch", {31'd0, s_ef}, 32'd1);
        chk("dlv1 CLR", {31'd0, s_clr}, 32'd0);
        cyc(1, 4, 0, 0, 1, 0, 0);
        chk("req2 addr", s_addr, 32'd4);
        cyc(1, 4, 0, 0, 0, 1, 32'h00100113);
        chk("dlv2 InstrDi", s_instr, 32'h00100113);
        cyc(1, 8, 0, 0, 1, 0, 0);
        cyc(1, 8, 0, 0, 0, 1, 32'h002081B3);
        chk("dlv3 InstrDi", s_instr, 32'h002081B3);
        chk("dlv3 en_decode", {31'd0, s_ed}, 32'd1);

        // Redirect during WAIT, late wrong-path response
        cyc(1, 32'h10, 0, 0, 1, 0, 0);
        chk("stream stall_cycles", {16'd0, s_cnt}, 32'd4);
        cyc(1, 32'h10, 2'b01, 0, 0, 0, 0);
        chk("wait flush en_fetch", {31'd0, s_ef}, 32'd1);
        chk("wait flush CLR", {31'd0, s_clr}, 32'd1);
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        chk("drop req", {31'd0, s_req}, 32'd0);
        cyc(1, 32'h40, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("drop discard InstrDi", s_instr, c_NOP);
        chk("drop discard CLR", {31'd0, s_clr}, 32'd1);
        cyc(1, 32'h40, 0, 0, 1, 0, 0);
        chk("post-drop req", {31'd0, s_req}, 32'd1);
        chk("post-drop addr", s_addr, 32'h40);

        // Response under load-use stall, buffered then delivered
        cyc(1, 32'h40, 0, 1, 0, 1, 32'h00A00513);
        chk("stall0 en_decode", {31'd0, s_ed}, 32'd0);
        repeat (2) begin
            cyc(1, 32'h40, 0, 1, 0, 0, 0);
            chk("hold req", {31'd0, s_req}, 32'd0);
            chk("hold en_decode", {31'd0, s_ed}, 32'd0);
        end
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        chk("hold release InstrDi", s_instr, 32'h00A00513);
        chk("hold release en_fetch", {31'd0, s_ef}, 32'd1);

        // Redirect + rvalid + stall in WAIT; redirect + gnt in REQ
        cyc(1, 32'h44, 0, 0, 1, 0, 0);
        cyc(1, 32'h44, 2'b10, 1, 0, 1, 32'h11111111);
        chk("triple InstrDi", s_instr, c_NOP);
        chk("triple en_decode", {31'd0, s_ed}, 32'd1);
        cyc(1, 32'h80, 2'b01, 0, 1, 0, 0);
        chk("req redirect addr", s_addr, 32'h80);
        cyc(1, 32'h90, 2'b11, 0, 0, 0, 0);
        chk("drop redirect req", {31'd0, s_req}, 32'd0);
        chk("drop redirect en_fetch", {31'd0, s_ef}, 32'd1);
        cyc(1, 32'hA0, 0, 0, 0, 1, 32'hCAFEF00D);
        chk("drop drain InstrDi", s_instr, c_NOP);
        cyc(1, 32'hA0, 2'b01, 0, 0, 0, 0);
        cyc(1, 32'hB0, 0, 0, 1, 0, 0);
        chk("retarget addr", s_addr, 32'hB0);
        cyc(1, 32'hB0, 0, 1, 0, 1, 32'h12345678);
        cyc(1, 32'hB0, 2'b01, 1, 0, 0, 0);
        chk("hold flush InstrDi", s_instr, c_NOP);
        chk("hold flush CLR", {31'd0, s_clr}, 32'd1);

        // Counter saturation with grant withheld
        repeat (70000) cyc(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("sat stall_cycles", {16'd0, s_cnt}, 32'h0000FFFF);
        cyc(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("sat hold stall_cycles", {16'd0, s_cnt}, 32'h0000FFFF);

        // Reset mid-fetch
        cyc(1, 32'hC0, 0, 0, 1, 0, 0);
        cyc(0, 32'hC0, 0, 0, 0, 0, 0);
        chk_reset_outputs("midreset");
        cyc(1, 32'hC0, 0, 0, 0, 0, 0);
        chk("midreset idle req", {31'd0, s_req}, 32'd0);
        chk("midreset stall_cycles", {16'd0, s_cnt}, 32'd0);
        cyc(1, 32'hC0, 0, 0, 1, 0, 0);
        chk("midreset req", {31'd0, s_req}, 32'd1);
        cyc(1, 32'hC0, 0, 0, 0, 1, 32'h00000033);
        chk("midreset InstrDi", s_instr, 32'h00000033);

        cyc(1, 32'hC4, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
